// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data access, data first; MEM_ARB_IBUF_EN adds a one-entry fetch buffer.
// Latency: ack in BUS cycle n gives a response in cycle n+1; a buffer hit responds one cycle after IDLE.
// Backpressure: each port stalls while its request is held and its RESP cycle has not arrived.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_ren,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic                  inst_stall,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    input  logic                  bus_ack
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUS_D  = 3'd1,
        BUS_I  = 3'd2,
        RESP_D = 3'd3,
        RESP_I = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  data_req;
    logic                  grant_d;
    logic                  grant_i;
    logic                  capture;
    logic [DATA_WIDTH-1:0] resp_dat;

    assign data_req   = mem_ren | mem_wen;
    assign inst_stall = inst_ren & (state != RESP_I);
    assign mem_stall  = data_req & (state != RESP_D);
    assign inst_data  = resp_dat;
    assign mem_din    = resp_dat;

`ifdef MEM_ARB_IBUF_EN
    logic                  ibuf_valid;
    logic [ADDR_WIDTH-1:0] ibuf_addr;
    logic [DATA_WIDTH-1:0] ibuf_data;
    logic                  ibuf_hit;
    logic                  take_ibuf;

    assign ibuf_hit = ibuf_valid && (inst_addr == ibuf_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        capture   = 1'b0;
`ifdef MEM_ARB_IBUF_EN
        take_ibuf = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (data_req) begin
                    state_nxt = BUS_D;
                    grant_d   = 1'b1;
                end else if (inst_ren) begin
`ifdef MEM_ARB_IBUF_EN
                    if (ibuf_hit) begin
                        state_nxt = RESP_I;
                        take_ibuf = 1'b1;
                    end else begin
                        state_nxt = BUS_I;
                        grant_i   = 1'b1;
                    end
`else
                    state_nxt = BUS_I;
                    grant_i   = 1'b1;
`endif
                end
            end
            BUS_D: begin
                if (bus_ack) begin
                    state_nxt = RESP_D;
                    capture   = 1'b1;
                end
            end
            BUS_I: begin
                if (bus_ack) begin
                    state_nxt = RESP_I;
                    capture   = 1'b1;
                end
            end
            RESP_D:  state_nxt = IDLE;
            RESP_I:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus fields are loaded only on grant, so they stay constant for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (grant_d) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_wen;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_dout;
        end else if (grant_i) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_addr  <= inst_addr;
        end else if (capture) begin
            bus_req   <= 1'b0;
        end
    end

    // A withdrawn request still lands here; the port simply ignores the RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_dat <= '0;
        end else if (capture) begin
            resp_dat <= bus_rdata;
`ifdef MEM_ARB_IBUF_EN
        end else if (take_ibuf) begin
            resp_dat <= ibuf_data;
`endif
        end
    end

`ifdef MEM_ARB_IBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf_valid <= 1'b0;
            ibuf_addr  <= '0;
            ibuf_data  <= '0;
        end else if (capture && (state == BUS_I)) begin
            ibuf_valid <= 1'b1;
            ibuf_addr  <= bus_addr;
            ibuf_data  <= bus_rdata;
        end else if (grant_d && mem_wen && (mem_addr == ibuf_addr)) begin
            ibuf_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bus responder model with programmable ack latency,
// expected bus transactions and port read data queued at stimulus time and checked on completion.
module tb_mem_arbiter;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_ren;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_stall;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_model [logic [31:0]];
    bus_txn_t    exp_bus [$];
    logic [31:0] exp_i [$];
    logic [31:0] exp_d [$];

    bit auto_ack = 1'b1;
    int ack_lat  = 1;
    int ack_cnt  = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst_ren  (inst_ren),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .inst_stall(inst_stall),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_stall (mem_stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Bus slave: acks after ack_lat BUS cycles, returning the memory model contents.
    always begin
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (bus_req && !bus_ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_we ? 32'hBAD0_0000 : mem_rd(bus_addr);
                    ack_cnt   = 0;
                end
            end else begin
                bus_ack = 1'b0;
                ack_cnt = 0;
            end
        end else begin
            ack_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_req) begin
            if (exp_bus.size() == 0) begin
                chk("bus_unexpected_req", 1, 0);
            end else begin
                chk("bus_we", bus_we, exp_bus[0].we);
                chk("bus_addr", bus_addr, exp_bus[0].addr);
                if (exp_bus[0].we) chk("bus_wdata", bus_wdata, exp_bus[0].wdata);
                if (bus_ack) void'(exp_bus.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && inst_ren && !inst_stall) begin
            if (exp_i.size() == 0) chk("inst_unexpected_done", 1, 0);
            else chk("inst_data", inst_data, exp_i.pop_front());
        end
        if (rst_n && mem_ren && !mem_stall) begin
            if (exp_d.size() == 0) chk("mem_unexpected_done", 1, 0);
            else chk("mem_din", mem_din, exp_d.pop_front());
        end
    end

    // Called at a drive point (just after a rising edge); returns at the drive point after completion.
    task automatic do_fetch(input logic [31:0] a, input bit push_bus, output int stalls);
        bus_txn_t t;
        stalls = 0;
        if (push_bus) begin
            t.we = 1'b0; t.addr = a; t.wdata = '0;
            exp_bus.push_back(t);
        end
        exp_i.push_back(mem_rd(a));
        inst_ren  = 1'b1;
        inst_addr = a;
        forever begin
            @(negedge clk);
            if (!inst_stall) break;
            stalls++;
            if (stalls > 50) begin
                chk("fetch_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        inst_ren = 1'b0;
    endtask

    task automatic do_mem(input bit we, input logic [31:0] a, input logic [31:0] d,
                          input bit push_bus, output int stalls);
        bus_txn_t t;
        stalls = 0;
        if (push_bus) begin
            t.we = we; t.addr = a; t.wdata = d;
            exp_bus.push_back(t);
        end
        if (we) mem_model[a] = d;
        else exp_d.push_back(mem_rd(a));
        mem_ren  = !we;
        mem_wen  = we;
        mem_addr = a;
        mem_dout = d;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            stalls++;
            if (stalls > 50) begin
                chk("mem_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        mem_ren = 1'b0;
        mem_wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       s, sd, si, lat;
        bus_txn_t t;

        rst_n = 1'b0; inst_ren = 1'b1; inst_addr = '0;
        mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0;
        bus_rdata = '0; bus_ack = 1'b0;

        @(negedge clk);
        chk("rst_inst_stall_req", inst_stall, 1);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_mem_stall", mem_stall, 0);
        inst_ren = 1'b0;
        #1;
        chk("rst_inst_stall_idle", inst_stall, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_bus_req", bus_req, 0);
            chk("idle_inst_stall", inst_stall, 0);
            chk("idle_mem_stall", mem_stall, 0);
        end
        chk("idle_state", 64'(dut.state), 0);
        @(posedge clk);
        #1;

        mem_model[32'h100] = 32'h2408_000A;
        ack_lat = 1;
        do_fetch(32'h100, 1, s);
        chk("single_fetch_stalls", s, 2);

        mem_model[32'h2000] = 32'h1111_2222;
        t.we = 1'b0; t.addr = 32'h2000; t.wdata = '0; exp_bus.push_back(t);
        t.we = 1'b0; t.addr = 32'h104;  t.wdata = '0; exp_bus.push_back(t);
        fork
            do_mem(1'b0, 32'h2000, 32'h0, 0, sd);
            do_fetch(32'h104, 0, si);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("contend_c4_bus_addr", bus_addr, 32'h104);
                chk("contend_c4_bus_req", bus_req, 1);
            end
        join
        chk("contend_mem_stalls", sd, 2);
        chk("contend_inst_stalls", si, 5);

        ack_lat = 4;
        do_mem(1'b1, 32'h3000, 32'hDEAD_BEEF, 1, s);
        chk("slow_write_stalls", s, 5);
        ack_lat = 2;
        do_mem(1'b0, 32'h3000, 32'h0, 1, s);
        chk("readback_stalls", s, 3);

        for (int i = 0; i < 8; i++) begin
            lat = $urandom_range(1, 3);
            ack_lat = lat;
            case ($urandom_range(0, 2))
                0: do_mem(1'b1, 32'h4000 + 32'(4 * (i % 4)), $urandom, 1, s);
                1: do_mem(1'b0, 32'h4000 + 32'(4 * (i % 4)), 32'h0, 1, s);
                default: do_fetch(32'h5000 + 32'(4 * i), 1, s);
            endcase
            chk("rand_stalls", s, lat + 1);
        end

        auto_ack = 1'b0;
        bus_ack  = 1'b0;
        t.we = 1'b0; t.addr = 32'h200; t.wdata = '0; exp_bus.push_back(t);
        inst_ren = 1'b1; inst_addr = 32'h200;
        @(negedge clk);
        chk("rstmid_c0_inst_stall", inst_stall, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid_c1_inst_stall", inst_stall, 1);
        chk("rstmid_c1_bus_req", bus_req, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        inst_ren = 1'b0;
        #1;
        chk("rstmid_bus_req_drop", bus_req, 0);
        chk("rstmid_state", 64'(dut.state), 0);
        exp_bus.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rstmid_c3_bus_req", bus_req, 0);
        chk("rstmid_c3_inst_data", inst_data, 0);
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_state", 64'(dut.state), 0);
        chk("late_ack_inst_data", inst_data, 0);
        chk("late_ack_bus_req", bus_req, 0);
        @(posedge clk);
        #1;
        auto_ack = 1'b1;
        ack_lat  = 1;

        do_fetch(32'h100, 1, s);
        chk("ibuf_first_stalls", s, 2);
`ifdef MEM_ARB_IBUF_EN
        do_fetch(32'h100, 0, s);
        chk("ibuf_hit_stalls", s, 1);
`else
        do_fetch(32'h100, 1, s);
        chk("ibuf_off_refetch_stalls", s, 2);
`endif
        do_mem(1'b1, 32'h100, 32'h0C00_FFEE, 1, s);
        chk("ibuf_write_stalls", s, 2);
        do_fetch(32'h100, 1, s);
        chk("ibuf_after_write_stalls", s, 2);

        repeat (3) @(negedge clk);
        chk("bus_queue_empty", exp_bus.size(), 0);
        chk("inst_queue_empty", exp_i.size(), 0);
        chk("mem_queue_empty", exp_d.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
